// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with valid qualification, selectable
// overlap and Mealy/Moore output, plus a saturating match counter and even parity.
module seq_detector_param #(
   parameter int             N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b0110,
   parameter bit             OVERLAP = 1'b1,
   parameter bit             MOORE   = 1'b0,
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             x_valid,
   output logic             z,
   output logic [CNT_W-1:0] match_count,
   output logic             even_par
);

   localparam int             FW       = $clog2(N);
   localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);

   logic [N-2:0]  hist;
   logic [FW-1:0] fill;
   logic [N-1:0]  cand;
   logic          hit;

   // The newest bit completes the candidate; fill keeps us from matching stale zeros
   assign cand = {hist, x};
   assign hit  = x_valid && (fill == FILL_MAX) && (cand == PATTERN);

   // History, fill level, match counter and parity advance only on accepted bits
   always_ff @(posedge clk) begin
      if (reset) begin
         hist        <= '0;
         fill        <= '0;
         match_count <= '0;
         even_par    <= 1'b1;
      end else if (x_valid) begin
         hist     <= cand[N-2:0];
         even_par <= even_par ^ x;
         if (hit && !OVERLAP) begin
            fill <= '0;
         end else if (fill != FILL_MAX) begin
            fill <= fill + 1'b1;
         end
         if (hit && !(&match_count)) begin
            match_count <= match_count + 1'b1;
         end
      end
   end

   generate
      if (MOORE) begin : g_moore
         logic z_q;

         // Registered indication holds across idle cycles until the next accepted bit
         always_ff @(posedge clk) begin
            if (reset) begin
               z_q <= 1'b0;
            end else if (x_valid) begin
               z_q <= hit;
            end
         end

         assign z = z_q;
      end else begin : g_mealy
         assign z = hit;
      end
   endgenerate

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector for a 1-bit input stream qualified by a valid strobe. It generalises the fixed 4-bit sequence detector in three ways: pattern length and value are parameters, overlapping and non-overlapping matching is selectable, and the output can be Mealy or Moore. It also provides a saturating match counter and a running even-parity flag over all accepted bits. It sits between a serial front end and control logic that consumes match pulses and counts.

Parameters:
N, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b0110, N-bit pattern; the MSB is the first bit received.
OVERLAP, 1, 1 = the suffix of a match may start the next match; 0 = history is discarded after each match.
MOORE, 0, 0 = Mealy z (combinational, same cycle as the last bit); 1 = Moore z (registered, one cycle later).
CNT_W, 8, width of match_count.

Ports:
clk  input  1  rising-edge clock, the only clock.
reset  input  1  synchronous, active-high reset.
x  input  1  serial data bit.
x_valid  input  1  x is accepted on a rising clk edge when x_valid=1; x is ignored otherwise.
z  output  1  match indication, Mealy or Moore per MOORE.
match_count  output  CNT_W  number of matches since reset; saturates.
even_par  output  1  1 when an even number of 1s has been accepted since reset.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, port name reset. Reset has priority over x_valid in the same cycle.
- Reset values:
  - hist = 0
  - fill = 0
  - Moore z register = 0
  - match_count = 0
  - even_par = 1
- State:
  - hist: N-1 bit shift register holding the most recent accepted bits.
  - fill: counter 0..N-1 of valid history bits, width $clog2(N); saturates at N-1.
- cand = {hist, x}, N bits wide.
- hit = x_valid & (fill == N-1) & (cand == PATTERN).
- On an accepted bit (x_valid=1, reset=0):
  - hist <= cand[N-2:0].
  - even_par <= even_par ^ x.
  - If hit and OVERLAP=0: fill <= 0.
  - Otherwise: fill <= min(fill+1, N-1).
  - If hit: match_count <= match_count+1, unless it is already all-ones, in which case it holds.
- When x_valid=0, all state holds, x is ignored, and Mealy z=0.
- Mealy (MOORE=0): z = hit, combinational. z must be driven in every path (no latch). It depends on the current x and x_valid.
- Moore (MOORE=1):
  - z is a register, z <= hit, updated only on accepted bits.
  - z holds its value across x_valid=0 cycles.
  - z is therefore one accepted-bit later than Mealy.
- Latency:
  - Mealy z: 0 cycles after the final pattern bit is presented.
  - Moore z: 1 cycle after it.
  - match_count and even_par: visible 1 cycle after the accepting edge.
- No false match before N bits have been accepted, including a PATTERN of all zeros immediately after reset. The fill counter enforces this.
- Reset mid-pattern discards partial history; a full N fresh bits are required afterwards.
- Back-to-back matches (OVERLAP=1, self-overlapping PATTERN):
  - z is high on consecutive accepted bits as required.
  - match_count increments once per accepted bit that hits.
- Width rules: match_count wraps never; it saturates at 2^CNT_W-1.

Test Plan:
- Defaults (N=4, PATTERN=0110, OVERLAP=1, MOORE=0), after reset, stream 0,1,1,0,1,1,0 with x_valid=1:
  - z pulses on bit 4 and bit 7, same cycle as the bit.
  - match_count=2.
  - even_par=1.
- Same stream with OVERLAP=0:
  - z only on bit 4.
  - match_count=1.
- Same stream with MOORE=1:
  - z is high the cycle after bits 4 and 7.
  - z holds through inserted x_valid=0 cycles until the next accepted bit.
- Stream 0,1,1,0 with 3 x_valid=0 cycles between each bit and x=1 during the gaps:
  - exactly one match.
  - z=0 during all gaps (Mealy).
- Stream 0,1,1, then reset held one cycle together with x_valid=1 and x=0, then stream 0:
  - no match.
  - match_count=0.
  - even_par=1 after the reset.
- CNT_W=2, five overlapping matches (0,1,1,0,1,1,0,1,1,0,1,1,0,1,1,0):
  - z pulses 5 times.
  - match_count saturates at 3.
  - PATTERN=0000: no z in the first 3 accepted zeros after reset; z on the 4th and on every subsequent 0 (OVERLAP=1).
